// File: rtl/image_stream_source.sv
// Raster-order frame streamer: reads one IMG_WIDTH x IMG_HEIGHT frame from a
// synchronous-read buffer and presents it as a valid-qualified pixel stream.
module image_stream_source #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 220,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Pause_In,
    output logic                  Mem_Rd_En,
    output logic [ADDR_WIDTH-1:0] Mem_Rd_Addr,
    input  logic [DATA_WIDHT-1:0] Mem_Rd_Data,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  End_Of_Line,
    output logic                  Frame_Done,
    output logic                  Busy
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [COL_W-1:0]        col_reg;
    logic [ROW_W-1:0]        row_reg;
    logic [DATA_WIDHT-1:0]   data_hold_reg;
    logic                    valid_reg;
    logic                    eol_reg;
    logic                    fd_reg;

    assign Mem_Rd_En   = (state_reg == STREAM) && !Pause_In;
    assign Mem_Rd_Addr = addr_reg;
    assign Busy        = (state_reg != IDLE);
    assign Valid_Out   = valid_reg;
    assign End_Of_Line = eol_reg;
    assign Frame_Done  = fd_reg;

    // Read data arrives in the Valid_Out cycle, so pass it straight through and
    // keep a copy so Data_Out holds its last pixel between valid beats.
    assign Data_Out = valid_reg ? Mem_Rd_Data : data_hold_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            data_hold_reg <= '0;
            valid_reg     <= 1'b0;
            eol_reg       <= 1'b0;
            fd_reg        <= 1'b0;
        end else begin
            valid_reg <= Mem_Rd_En;
            eol_reg   <= Mem_Rd_En && (col_reg == COL_LAST);
            fd_reg    <= Mem_Rd_En && (addr_reg == LAST_ADDR);
            if (valid_reg) begin
                data_hold_reg <= Mem_Rd_Data;
            end

            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        state_reg <= STREAM;
                        addr_reg  <= '0;
                        col_reg   <= '0;
                        row_reg   <= '0;
                    end
                end
                STREAM: begin
                    if (Mem_Rd_En) begin
                        // Counters stop on the final pixel so the address never
                        // runs past the end of the frame.
                        if ((row_reg == ROW_LAST) && (col_reg == COL_LAST)) begin
                            state_reg <= DRAIN;
                        end else begin
                            addr_reg <= addr_reg + ADDR_WIDTH'(1);
                            if (col_reg == COL_LAST) begin
                                col_reg <= '0;
                                row_reg <= row_reg + ROW_W'(1);
                            end else begin
                                col_reg <= col_reg + COL_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench: a 4x3 instance for protocol scenarios and a default 220x220
// instance for full-frame counts, each fed by a 1-cycle-latency memory model.
module tb_image_stream_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst;
    logic        start, pause;
    logic        s_en;
    logic [3:0]  s_addr;
    logic [31:0] s_mem, s_dout;
    logic        s_v, s_eol, s_fd, s_busy;

    logic        b_start;
    logic        b_pause;
    logic        b_en;
    logic [15:0] b_addr;
    logic [31:0] b_mem, b_dout;
    logic        b_v, b_eol, b_fd, b_busy;

    image_stream_source #(
        .DATA_WIDHT(32), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_WIDTH(4)
    ) dut_small (
        .clk(clk), .rst(rst), .Start(start), .Pause_In(pause),
        .Mem_Rd_En(s_en), .Mem_Rd_Addr(s_addr), .Mem_Rd_Data(s_mem),
        .Data_Out(s_dout), .Valid_Out(s_v), .End_Of_Line(s_eol),
        .Frame_Done(s_fd), .Busy(s_busy)
    );

    image_stream_source dut_big (
        .clk(clk), .rst(rst), .Start(b_start), .Pause_In(b_pause),
        .Mem_Rd_En(b_en), .Mem_Rd_Addr(b_addr), .Mem_Rd_Data(b_mem),
        .Data_Out(b_dout), .Valid_Out(b_v), .End_Of_Line(b_eol),
        .Frame_Done(b_fd), .Busy(b_busy)
    );

    // Frame buffers: word k holds 3f800000+k, read data one cycle after enable
    always @(posedge clk) if (s_en) s_mem <= 32'h3f800000 + 32'(s_addr);
    always @(posedge clk) if (b_en) b_mem <= 32'h3f800000 + 32'(b_addr);

    logic        rec_v    [64];
    logic        rec_eol  [64];
    logic        rec_fd   [64];
    logic        rec_busy [64];
    logic        rec_en   [64];
    logic [3:0]  rec_addr [64];
    logic [31:0] rec_d    [64];

    // Records the small DUT's outputs for ncyc cycles; optionally pauses for
    // 3 cycles after address pause_addr is issued and pulses Start while
    // pixel start_pix is being output.
    task automatic capture(input int ncyc, input int pause_addr, input int start_pix);
        int pause_left = 0;
        int pix = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            rec_v[c] = s_v; rec_d[c] = s_dout; rec_eol[c] = s_eol;
            rec_fd[c] = s_fd; rec_busy[c] = s_busy;
            start = s_v && (pix == start_pix);
            if (s_v) begin
                $display("cyc %0d pix %0d data=%h eol=%0b fd=%0b", c, pix, s_dout, s_eol, s_fd);
                pix++;
            end
            pause = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            #1;
            rec_en[c] = s_en; rec_addr[c] = s_addr;
            if (s_en && int'(s_addr) == pause_addr) pause_left = 3;
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++; if (s_v !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%0b want=0", s_v); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", s_busy); end
        checks++; if (s_en !== 1'b0)  begin errors++; $display("FAIL reset_rd_en got=%0b want=0", s_en); end
        checks++; if (s_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", s_addr); end
        checks++; if (s_dout !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", s_dout); end
        checks++; if ({s_eol, s_fd} !== 2'b00) begin errors++; $display("FAIL reset_markers got=%b want=00", {s_eol, s_fd}); end
        checks++; if ({b_v, b_busy, b_en} !== 3'b000) begin errors++; $display("FAIL reset_big got=%b want=000", {b_v, b_busy, b_en}); end
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_frame;
        @(posedge clk); #1;
        start = 1'b1;
        capture(20, -1, -1);
        checks++; if (rec_v[0] !== 1'b0 || rec_en[0] !== 1'b1 || rec_addr[0] !== 4'd0)
            begin errors++; $display("FAIL frame_first_read got v=%0b en=%0b addr=%0d want v=0 en=1 addr=0", rec_v[0], rec_en[0], rec_addr[0]); end
        checks++; if (rec_busy[0] !== 1'b1) begin errors++; $display("FAIL frame_busy_rise got=%0b want=1", rec_busy[0]); end
        for (int p = 0; p < 12; p++) begin
            checks++; if (rec_v[p+1] !== 1'b1 || rec_d[p+1] !== 32'h3f800000 + 32'(p))
                begin errors++; $display("FAIL frame_pix%0d got v=%0b d=%h want v=1 d=%h", p, rec_v[p+1], rec_d[p+1], 32'h3f800000 + 32'(p)); end
            checks++; if (rec_eol[p+1] !== (p % 4 == 3) || rec_fd[p+1] !== (p == 11))
                begin errors++; $display("FAIL frame_marks%0d got eol=%0b fd=%0b want eol=%0b fd=%0b", p, rec_eol[p+1], rec_fd[p+1], p % 4 == 3, p == 11); end
        end
        checks++; if (rec_busy[12] !== 1'b1 || rec_busy[13] !== 1'b0)
            begin errors++; $display("FAIL frame_busy_fall got=%0b%0b want=10", rec_busy[12], rec_busy[13]); end
        checks++; if (rec_v[13] !== 1'b0 || rec_d[13] !== 32'h3f80000b)
            begin errors++; $display("FAIL frame_hold got v=%0b d=%h want v=0 d=3f80000b", rec_v[13], rec_d[13]); end
    endtask

    task automatic test_pause;
        int n = 0;
        int first_c = -1;
        int last_c = -1;
        int fd_n = 0;
        start = 1'b1;
        capture(24, 5, -1);
        checks++; if (rec_v[6] !== 1'b1 || rec_d[6] !== 32'h3f800005)
            begin errors++; $display("FAIL pause_inflight got v=%0b d=%h want v=1 d=3f800005", rec_v[6], rec_d[6]); end
        checks++; if ({rec_v[7], rec_v[8], rec_v[9]} !== 3'b000)
            begin errors++; $display("FAIL pause_gap got=%b want=000", {rec_v[7], rec_v[8], rec_v[9]}); end
        for (int c = 0; c < 24; c++) begin
            if (rec_v[c]) begin
                checks++; if (rec_d[c] !== 32'h3f800000 + 32'(n))
                    begin errors++; $display("FAIL pause_order%0d got=%h want=%h", n, rec_d[c], 32'h3f800000 + 32'(n)); end
                if (first_c < 0) first_c = c;
                last_c = c;
                n++;
            end
            if (rec_fd[c]) fd_n++;
        end
        checks++; if (n !== 12) begin errors++; $display("FAIL pause_count got=%0d want=12", n); end
        checks++; if (last_c - first_c + 1 !== 15) begin errors++; $display("FAIL pause_span got=%0d want=15", last_c - first_c + 1); end
        checks++; if (fd_n !== 1 || rec_fd[15] !== 1'b1) begin errors++; $display("FAIL pause_done got n=%0d at15=%0b want n=1 at15=1", fd_n, rec_fd[15]); end
    endtask

    task automatic test_start_busy;
        int n = 0;
        int fd_n = 0;
        int idle_v = 0;
        start = 1'b1;
        capture(20, -1, 6);
        for (int c = 0; c < 20; c++) begin
            if (rec_v[c]) n++;
            if (rec_fd[c]) fd_n++;
        end
        checks++; if (n !== 12 || fd_n !== 1) begin errors++; $display("FAIL busy_start got pix=%0d fd=%0d want 12 1", n, fd_n); end
        checks++; if (rec_busy[19] !== 1'b0) begin errors++; $display("FAIL busy_after got=%0b want=0", rec_busy[19]); end
        // Start coinciding with Frame_Done lands in DRAIN and must be dropped
        start = 1'b1;
        capture(20, -1, 11);
        capture(8, -1, -1);
        for (int c = 0; c < 8; c++) if (rec_v[c] || rec_busy[c] || rec_en[c]) idle_v++;
        checks++; if (idle_v !== 0) begin errors++; $display("FAIL drain_start got active=%0d want=0", idle_v); end
        start = 1'b1;
        capture(20, -1, -1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (rec_v[c]) begin
                checks++; if (rec_d[c] !== 32'h3f800000 + 32'(n))
                    begin errors++; $display("FAIL second_frame%0d got=%h want=%h", n, rec_d[c], 32'h3f800000 + 32'(n)); end
                n++;
            end
        end
        checks++; if (n !== 12) begin errors++; $display("FAIL second_count got=%0d want=12", n); end
    endtask

    task automatic test_async_reset;
        bit found = 0;
        int fd_seen = 0;
        int n = 0;
        start = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (s_fd) fd_seen++;
            if (s_v && s_dout === 32'h3f800007) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL areset_pix7 got=missing want=seen"); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({s_v, s_busy, s_en, s_fd} !== 4'b0000)
            begin errors++; $display("FAIL areset_now got v/busy/en/fd=%b want=0000", {s_v, s_busy, s_en, s_fd}); end
        @(posedge clk); #1;
        if (s_fd) fd_seen++;
        checks++; if (fd_seen !== 0) begin errors++; $display("FAIL areset_no_done got=%0d want=0", fd_seen); end
        rst = 1'b1;
        $display("async reset applied and released");
        @(posedge clk); #1;
        start = 1'b1;
        capture(20, -1, -1);
        checks++; if (rec_en[0] !== 1'b1 || rec_addr[0] !== 4'd0)
            begin errors++; $display("FAIL areset_restart got en=%0b addr=%0d want en=1 addr=0", rec_en[0], rec_addr[0]); end
        for (int c = 0; c < 20; c++) if (rec_v[c]) n++;
        checks++; if (n !== 12 || rec_d[1] !== 32'h3f800000)
            begin errors++; $display("FAIL areset_frame got pix=%0d d0=%h want 12 3f800000", n, rec_d[1]); end
    endtask

    task automatic test_full_size;
        int nv = 0, n_eol = 0, n_fd = 0, bad = 0;
        int first_c = -1, last_c = -1;
        int last_addr = -1, max_addr = 0;
        bit done = 0;
        b_start = 1'b1;
        for (int c = 0; c < 48700 && !done; c++) begin
            @(posedge clk); #1;
            b_start = 1'b0;
            if (b_en) begin
                last_addr = int'(b_addr);
                if (int'(b_addr) > max_addr) max_addr = int'(b_addr);
            end
            if (b_v) begin
                if (b_dout !== 32'h3f800000 + 32'(nv)) bad++;
                if (b_eol !== (nv % 220 == 219)) bad++;
                if (first_c < 0) first_c = c;
                last_c = c;
                nv++;
            end
            if (b_eol) n_eol++;
            if (b_fd) n_fd++;
            if (nv > 0 && !b_busy && !b_v) done = 1;
        end
        $display("full frame: pixels=%0d eol=%0d fd=%0d last_addr=%0d", nv, n_eol, n_fd, last_addr);
        checks++; if (nv !== 48400) begin errors++; $display("FAIL full_pixels got=%0d want=48400", nv); end
        checks++; if (last_c - first_c + 1 !== 48400) begin errors++; $display("FAIL full_span got=%0d want=48400", last_c - first_c + 1); end
        checks++; if (n_eol !== 220) begin errors++; $display("FAIL full_eol got=%0d want=220", n_eol); end
        checks++; if (n_fd !== 1) begin errors++; $display("FAIL full_done got=%0d want=1", n_fd); end
        checks++; if (last_addr !== 48399 || max_addr !== 48399)
            begin errors++; $display("FAIL full_addr got last=%0d max=%0d want 48399", last_addr, max_addr); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_data got bad=%0d want=0", bad); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pause = 1'b0; b_start = 1'b0; b_pause = 1'b0;
        repeat (2) @(posedge clk);
        test_reset;
        test_frame;
        test_pause;
        test_start_busy;
        test_async_reset;
        test_full_size;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
